incline_cond: RTL

Downstream conditioning stage for the inertial interface. It accepts each valid 13-bit signed incline sample and produces three things for the assist/PID logic: a saturated 10-bit incline, an exponentially averaged incline, and a staleness flag. The flag asserts when the sensor stops delivering samples. All outputs are registered.

---
 rtl/incline_pkg.sv | 27 ++
 rtl/stale_wdog.sv | 37 +++
 rtl/incline_cond.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/incline_pkg.sv
// Shared widths, limits, FSM encoding and saturation helper for the incline conditioning path.
package incline_pkg;

  localparam int unsigned INCL_W  = 13;
  localparam int unsigned SAT_W   = 10;
  localparam int          SAT_MAX = 511;
  localparam int          SAT_MIN = -512;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    STALE = 2'd3
  } state_e;

  // Clip a raw incline sample into the 10-bit signed output range.
  function automatic logic signed [SAT_W-1:0] sat_incl(input logic signed [INCL_W-1:0] x);
    if (x > INCL_W'(SAT_MAX)) begin
      return SAT_W'(SAT_MAX);
    end else if (x < INCL_W'(SAT_MIN)) begin
      return SAT_W'(SAT_MIN);
    end else begin
      return SAT_W'(x);
    end
  endfunction

endpackage

// File: rtl/stale_wdog.sv
// Saturating idle-cycle counter; flags when the sensor has been silent for TIMEOUT cycles.
module stale_wdog #(
  parameter int unsigned TIMEOUT = 1048575
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_W'(TIMEOUT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // High when the coming edge completes (or has completed) TIMEOUT idle cycles,
  // so the consumer can register its stale state on that same edge.
  assign expired = cnt_q >= CNT_W'(TIMEOUT - 1);

endmodule

// File: rtl/incline_cond.sv
// Incline conditioning: saturation, primed exponential average and sensor-staleness detection.
module incline_cond
  import incline_pkg::*;
#(
  parameter int unsigned AVG_LOG2 = 4,
  parameter int unsigned TIMEOUT  = 1048575
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     vld,
  input  logic signed [INCL_W-1:0] incline,
  output logic signed [SAT_W-1:0]  incline_sat,
  output logic signed [SAT_W-1:0]  incline_avg,
  output logic                     avg_vld,
  output logic                     upd,
  output logic                     stale
);

  localparam int unsigned ACC_W = 11 + AVG_LOG2;
  localparam int unsigned CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] PRIME_N = {1'b1, {AVG_LOG2{1'b0}}};

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         smp_cnt_q, smp_cnt_d;
  logic signed [SAT_W-1:0]  incline_sat_q, incline_sat_d;
  logic signed [SAT_W-1:0]  incline_avg_q, incline_avg_d;
  logic                     avg_vld_q, avg_vld_d;
  logic                     upd_q, upd_d;
  logic                     stale_q, stale_d;

  logic signed [SAT_W-1:0]  sat_c;
  logic signed [ACC_W-1:0]  sat_ext_c;
  logic signed [ACC_W-1:0]  acc_load_c;
  logic signed [ACC_W-1:0]  acc_upd_c;
  logic signed [ACC_W-1:0]  acc_shr_c;
  logic [CNT_W-1:0]         smp_cnt_inc_c;
  logic                     expired_c;

  stale_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_stale_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (vld),
    .expired (expired_c)
  );

  // Datapath: clip, then either seed or leak-and-add into the accumulator.
  always_comb begin
    sat_c         = sat_incl(incline);
    sat_ext_c     = {{(ACC_W - SAT_W){sat_c[SAT_W-1]}}, sat_c};
    acc_load_c    = sat_ext_c <<< AVG_LOG2;
    acc_upd_c     = acc_q - (acc_q >>> AVG_LOG2) + sat_ext_c;
    smp_cnt_inc_c = smp_cnt_q + CNT_W'(1);
  end

  // Sample handling wins over a same-cycle watchdog expiry in every state.
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    smp_cnt_d     = smp_cnt_q;
    avg_vld_d     = avg_vld_q;
    stale_d       = stale_q;
    upd_d         = vld;
    incline_sat_d = vld ? sat_c : incline_sat_q;

    unique case (state_q)
      IDLE, STALE: begin
        if (vld) begin
          acc_d     = acc_load_c;
          smp_cnt_d = CNT_W'(1);
          stale_d   = 1'b0;
          state_d   = PRIME;
        end else if (expired_c && (state_q == IDLE)) begin
          stale_d   = 1'b1;
          avg_vld_d = 1'b0;
          state_d   = STALE;
        end
      end
      PRIME: begin
        if (vld) begin
          acc_d     = acc_upd_c;
          smp_cnt_d = smp_cnt_inc_c;
          if (smp_cnt_inc_c == PRIME_N) begin
            avg_vld_d = 1'b1;
            state_d   = RUN;
          end
        end else if (expired_c) begin
          stale_d   = 1'b1;
          avg_vld_d = 1'b0;
          state_d   = STALE;
        end
      end
      RUN: begin
        if (vld) begin
          acc_d = acc_upd_c;
        end else if (expired_c) begin
          stale_d   = 1'b1;
          avg_vld_d = 1'b0;
          state_d   = STALE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    acc_shr_c     = acc_d >>> AVG_LOG2;
    incline_avg_d = acc_shr_c[SAT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      smp_cnt_q     <= '0;
      incline_sat_q <= '0;
      incline_avg_q <= '0;
      avg_vld_q     <= 1'b0;
      upd_q         <= 1'b0;
      stale_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      smp_cnt_q     <= smp_cnt_d;
      incline_sat_q <= incline_sat_d;
      incline_avg_q <= incline_avg_d;
      avg_vld_q     <= avg_vld_d;
      upd_q         <= upd_d;
      stale_q       <= stale_d;
    end
  end

  assign incline_sat = incline_sat_q;
  assign incline_avg = incline_avg_q;
  assign avg_vld     = avg_vld_q;
  assign upd         = upd_q;
  assign stale       = stale_q;

endmodule
